yonga_can_mailbox_regs: RTL and testbench
=========================================

YONGA_CAN_MAILBOX_REGS -- requirements
Module: yonga_can_mailbox_regs

Interface
REQ-001 Parameter NUM_MB, default 4, number of transmit mailboxes; legal range 1..8.
REQ-002 Parameter RETRY_MAX, default 3, automatic retransmissions after arbitration loss; legal range 0..15.
REQ-003 Parameter BITS, default 32, register/bus data width; only 32 is legal.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk.
REQ-006 valid  input  1  bus request qualifier.
REQ-007 ready  output  1  one-cycle bus acknowledge.
REQ-008 wr_en  input  1  1 = write, 0 = read.
REQ-009 addr  input  8  byte address, word-aligned.
REQ-010 wdata  input  BITS  write data.
REQ-011 wstrb  input  4  byte write strobes.
REQ-012 rdata  output  BITS  read data, valid while ready=1.
REQ-013 o_baud_cfg  output  27  BAUD_RATE_CFG[26:0] to the pulse generator.
REQ-014 o_cfg_enable  output  1  SYS_CFG[1], to the controller.
REQ-015 o_send  output  1  one-cycle transmit request to the controller.
REQ-016 o_msg_id, o_msg_cfg, o_data1, o_data2  output  30/5/32/32  selected mailbox fields, stable from o_send until the result is taken.
REQ-017 i_sts_code  input  3  controller result: 001 success, 010 arbitration lost, 011 transmit failed, 000 none.
REQ-018 o_irq  output  1  level interrupt, equal to OR(IRQ_STS & IRQ_EN).
REQ-019 o_busy  output  1  high in states SEND and WAIT.

Function
REQ-020 The global registers SHALL be at: 0x00 BAUD_RATE_CFG, 0x04 SYS_CFG (bit0 TX_EN, bit1 CFG_EN), 0x08 PENDING, 0x0C IRQ_STS, 0x10 IRQ_EN, 0x14 LAST_STS.
REQ-021 Mailbox n SHALL be at base 0x20+0x10*n, with offsets +0 MSG_ID, +4 MSG_CFG, +8 DATA1, +C DATA2.
REQ-022 Accesses to unmapped addresses, or to mailbox n >= NUM_MB, SHALL read 0 and ignore writes.
REQ-023 The bus SHALL set ready for exactly one cycle, the cycle after valid is sampled high with ready low; rdata SHALL be registered; wstrb SHALL gate each byte.
REQ-024 BAUD_RATE_CFG SHALL be writable only while CFG_EN=1.
REQ-025 A mailbox write SHALL be ignored while that mailbox's PENDING bit is 1.
REQ-026 PENDING writes SHALL be write-1-to-set, with bit NUM_MB..31 ignored; reads return the live bits; hardware clears bits.
REQ-027 IRQ_STS SHALL be write-1-to-clear; bit n sets on completion of mailbox n (success, failure, or retries exhausted).
REQ-028 If a hardware set and a software clear of the same IRQ_STS bit occur in the same cycle, the set SHALL win.
REQ-029 LAST_STS SHALL hold {mailbox index[18:16], retry count[11:8], final status code[2:0]} of the last completed transmission.
REQ-030 The scheduler FSM SHALL have the states IDLE, SELECT, SEND, WAIT.
REQ-031 IDLE to SELECT SHALL occur when TX_EN=1, CFG_EN=0 and PENDING is not zero.
REQ-032 SELECT SHALL take one cycle and choose the pending mailbox with the numerically lowest MSG_ID[29:0]; on equal IDs, the lowest index wins; the choice is latched into a current-index register.
REQ-033 SEND SHALL assert o_send for one cycle and then go to WAIT.
REQ-034 In WAIT, the first cycle with i_sts_code not 000 SHALL be taken as the result.
REQ-035 Result 001 or 011 SHALL clear PENDING[cur], set IRQ_STS[cur], update LAST_STS, and return to IDLE.
REQ-036 Result 010 with retry count < RETRY_MAX SHALL increment the retry count and go to SELECT, re-arbitrating among all pending mailboxes.
REQ-037 Result 010 with retry count = RETRY_MAX SHALL be treated as final: clear PENDING[cur], set IRQ_STS[cur], and record 010.
REQ-038 The retry count SHALL reset to 0 on each IDLE to SELECT transition.
REQ-039 Writing TX_EN=0 during WAIT SHALL NOT abort the transmission in progress; the FSM returns to IDLE and then stays idle.

Reset
REQ-040 While rst_n=0, all registers SHALL be 0, the FSM SHALL be in IDLE, and ready, rdata, o_send, o_irq and o_busy SHALL be 0.
REQ-041 o_msg_id, o_msg_cfg, o_data1 and o_data2 SHALL be 0 under reset.
REQ-042 A reset asserted mid-transmission SHALL discard all pending requests with no interrupt.

Verification
REQ-043 Write BAUD_RATE_CFG=0x0012_3456 with CFG_EN=0, then read it -> reads 0; set CFG_EN=1 and write again -> reads 0x0012_3456, o_baud_cfg=0x012_3456.
REQ-044 Load mailbox 0 ID=0x100 and mailbox 2 ID=0x080, write PENDING=0x5, TX_EN=1 -> first o_send carries ID 0x080; after result 001, the second o_send carries 0x100; IRQ_STS=0x5.
REQ-045 Mailbox 1 pending, return 010 four times with RETRY_MAX=3 -> four o_send pulses in total, PENDING[1]=0, LAST_STS=0x0001_0302.
REQ-046 IRQ_EN=0x1, completion of mailbox 0 -> o_irq=1; write IRQ_STS=0x1 in the same cycle as a new completion of mailbox 0 -> bit stays 1.
REQ-047 Write mailbox 0 DATA1 while PENDING[0]=1 -> value unchanged; reset during WAIT -> PENDING=0, o_busy=0, no further o_send.

Source files
------------

// File: rtl/yonga_can_mailbox_regs.sv
// CAN transmit mailbox register block: bus-mapped configuration, per-mailbox
// message storage, and a lowest-ID-first scheduler that hands frames to the controller.
module yonga_can_mailbox_regs #(
  parameter int NUM_MB    = 4,
  parameter int RETRY_MAX = 3,
  parameter int BITS      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  output logic            ready,
  input  logic            wr_en,
  input  logic [7:0]      addr,
  input  logic [BITS-1:0] wdata,
  input  logic [3:0]      wstrb,
  output logic [BITS-1:0] rdata,
  output logic [26:0]     o_baud_cfg,
  output logic            o_cfg_enable,
  output logic            o_send,
  output logic [29:0]     o_msg_id,
  output logic [4:0]      o_msg_cfg,
  output logic [31:0]     o_data1,
  output logic [31:0]     o_data2,
  input  logic [2:0]      i_sts_code,
  output logic            o_irq,
  output logic            o_busy
);

  localparam int IW = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
  localparam logic [3:0] NMB  = 4'(NUM_MB);
  localparam logic [3:0] RMAX = 4'(RETRY_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [BITS-1:0]   baud;
  logic              tx_en;
  logic              cfg_en;
  logic [NUM_MB-1:0] pending;
  logic [NUM_MB-1:0] irq_sts;
  logic [NUM_MB-1:0] irq_en;
  logic [29:0]       mb_id  [NUM_MB];
  logic [4:0]        mb_cfg [NUM_MB];
  logic [31:0]       mb_d1  [NUM_MB];
  logic [31:0]       mb_d2  [NUM_MB];

  logic [1:0]        state;
  logic [IW-1:0]     cur;
  logic [3:0]        retry;
  logic [2:0]        last_idx;
  logic [3:0]        last_retry;
  logic [2:0]        last_code;

  logic              access;
  logic              wr_acc;
  logic [3:0]        mb_n;
  logic              mb_hit;
  logic [IW-1:0]     mb_idx;
  logic [5:0]        word;
  logic [BITS-1:0]   wmask;
  logic [BITS-1:0]   wd;
  logic [BITS-1:0]   rd_val;
  logic [BITS-1:0]   merged;
  logic [NUM_MB-1:0] sw_set;
  logic [NUM_MB-1:0] sw_clr;
  logic [NUM_MB-1:0] done_vec;
  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic [29:0]       sel_id;
  logic              take;
  logic              retry_go;
  logic              tx_done;
  logic              unused_addr;

  assign access      = valid && !ready;
  assign wr_acc      = access && wr_en;
  assign word        = addr[7:2];
  assign mb_n        = addr[7:4] - 4'd2;
  assign mb_hit      = (addr[7:4] >= 4'd2) && (mb_n < NMB);
  assign mb_idx      = mb_n[IW-1:0];
  assign wmask       = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign wd          = wdata & wmask;
  assign merged      = (rd_val & ~wmask) | wd;
  assign unused_addr = &{1'b0, addr[1:0]};

  // Read mux doubles as the "old value" for byte-merged writes
  always_comb begin
    rd_val = '0;
    if (mb_hit) begin
      case (addr[3:2])
        2'd0:    rd_val = {2'b00, mb_id[mb_idx]};
        2'd1:    rd_val = {27'd0, mb_cfg[mb_idx]};
        2'd2:    rd_val = mb_d1[mb_idx];
        default: rd_val = mb_d2[mb_idx];
      endcase
    end else begin
      case (word)
        6'h00:   rd_val = baud;
        6'h01:   rd_val = {30'd0, cfg_en, tx_en};
        6'h02:   rd_val[NUM_MB-1:0] = pending;
        6'h03:   rd_val[NUM_MB-1:0] = irq_sts;
        6'h04:   rd_val[NUM_MB-1:0] = irq_en;
        6'h05:   rd_val = {13'd0, last_idx, 4'd0, last_retry, 5'd0, last_code};
        default: rd_val = '0;
      endcase
    end
  end

  assign sw_set = (wr_acc && !mb_hit && word == 6'h02) ? wd[NUM_MB-1:0] : '0;
  assign sw_clr = (wr_acc && !mb_hit && word == 6'h03) ? wd[NUM_MB-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready  <= 1'b0;
      rdata  <= '0;
      baud   <= '0;
      tx_en  <= 1'b0;
      cfg_en <= 1'b0;
      irq_en <= '0;
      for (int i = 0; i < NUM_MB; i++) begin
        mb_id[i]  <= '0;
        mb_cfg[i] <= '0;
        mb_d1[i]  <= '0;
        mb_d2[i]  <= '0;
      end
    end else begin
      ready <= access;
      rdata <= (access && !wr_en) ? rd_val : '0;
      if (wr_acc) begin
        // Mailbox contents are frozen while queued so the controller sees stable fields
        if (mb_hit) begin
          if (!pending[mb_idx]) begin
            case (addr[3:2])
              2'd0:    mb_id[mb_idx]  <= merged[29:0];
              2'd1:    mb_cfg[mb_idx] <= merged[4:0];
              2'd2:    mb_d1[mb_idx]  <= merged;
              default: mb_d2[mb_idx]  <= merged;
            endcase
          end
        end else begin
          case (word)
            6'h00:   if (cfg_en) baud <= merged;
            6'h01:   {cfg_en, tx_en} <= merged[1:0];
            6'h04:   irq_en <= merged[NUM_MB-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Strict less-than keeps the lowest index on equal IDs
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending[i] && (!sel_found || mb_id[i] < sel_id)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        sel_id    = mb_id[i];
      end
    end
  end

  assign take     = (state == S_WAIT) && (i_sts_code != 3'b000);
  assign retry_go = take && (i_sts_code == 3'b010) && (retry < RMAX);
  assign tx_done  = take && !retry_go;

  always_comb begin
    done_vec = '0;
    if (tx_done) done_vec[cur] = 1'b1;
  end

  // Hardware set of an IRQ bit is applied after the software clear, so it wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur        <= '0;
      retry      <= '0;
      pending    <= '0;
      irq_sts    <= '0;
      last_idx   <= '0;
      last_retry <= '0;
      last_code  <= '0;
    end else begin
      pending <= (pending & ~done_vec) | sw_set;
      irq_sts <= (irq_sts & ~sw_clr) | done_vec;
      case (state)
        S_IDLE: begin
          if (tx_en && !cfg_en && (|pending)) begin
            state <= S_SELECT;
            retry <= '0;
          end
        end
        S_SELECT: begin
          if (sel_found) begin
            cur   <= sel_idx;
            state <= S_SEND;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SEND: state <= S_WAIT;
        S_WAIT: begin
          if (retry_go) begin
            retry <= retry + 4'd1;
            state <= S_SELECT;
          end else if (tx_done) begin
            last_idx   <= 3'(cur);
            last_retry <= retry;
            last_code  <= i_sts_code;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_baud_cfg   = baud[26:0];
  assign o_cfg_enable = cfg_en;
  assign o_send       = (state == S_SEND);
  assign o_busy       = (state == S_SEND) || (state == S_WAIT);
  assign o_irq        = |(irq_sts & irq_en);
  assign o_msg_id     = mb_id[cur];
  assign o_msg_cfg    = mb_cfg[cur];
  assign o_data1      = mb_d1[cur];
  assign o_data2      = mb_d2[cur];

endmodule

// File: tb/tb_yonga_can_mailbox_regs.sv
// Randomized self-checking bench for yonga_can_mailbox_regs with a
// mailbox-level reference model (ID priority, retry budget, W1S/W1C registers).
module tb_yonga_can_mailbox_regs;

  localparam int NUM_MB    = 4;
  localparam int RETRY_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [2:0]  i_sts_code = '0;
  logic        ready;
  logic [31:0] rdata;
  logic [26:0] o_baud_cfg;
  logic        o_cfg_enable;
  logic        o_send;
  logic [29:0] o_msg_id;
  logic [4:0]  o_msg_cfg;
  logic [31:0] o_data1;
  logic [31:0] o_data2;
  logic        o_irq;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  // model state
  logic [29:0] m_id  [NUM_MB];
  logic [4:0]  m_cfg [NUM_MB];
  logic [31:0] m_d1  [NUM_MB];
  logic [31:0] m_d2  [NUM_MB];

  always #5 clk = ~clk;

  yonga_can_mailbox_regs #(.NUM_MB(NUM_MB), .RETRY_MAX(RETRY_MAX), .BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .wr_en(wr_en),
    .addr(addr), .wdata(wdata), .wstrb(wstrb), .rdata(rdata),
    .o_baud_cfg(o_baud_cfg), .o_cfg_enable(o_cfg_enable), .o_send(o_send),
    .o_msg_id(o_msg_id), .o_msg_cfg(o_msg_cfg), .o_data1(o_data1), .o_data2(o_data2),
    .i_sts_code(i_sts_code), .o_irq(o_irq), .o_busy(o_busy)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic bus_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    @(negedge clk);
    valid = 1'b1; wr_en = w; addr = a; wdata = d; wstrb = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        rd  = rdata;
      end
    end
    valid = 1'b0; wr_en = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL bus_ready addr=%h: ready never rose (wanted 1 within 8 cycles)", a);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus_access(1'b1, a, d, s, dummy);
  endtask

  task automatic rd_check(input string nm, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_access(1'b0, a, 32'h0, 4'h0, v);
    total++;
    if (v !== exp) begin
      bad++;
      $display("[TB] FAIL %s addr=%h: got %h, expected %h", nm, a, v, exp);
    end
  endtask

  task automatic wait_send(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (o_send) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL send_timeout: o_send=0 after 60 cycles, expected a pulse");
    end
  endtask

  // called at the negedge where o_send is high; result is taken two edges later
  task automatic respond(input logic [2:0] code);
    i_sts_code = code;
    @(negedge clk);
    @(negedge clk);
    i_sts_code = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ready, o_send, o_irq, o_busy} !== 4'b0000 || rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: ready/send/irq/busy=%b rdata=%h, expected 0000/0",
               {ready, o_send, o_irq, o_busy}, rdata);
    end
    total++;
    if (o_msg_id !== 30'h0 || o_data1 !== 32'h0 || o_data2 !== 32'h0 || o_msg_cfg !== 5'h0 ||
        o_baud_cfg !== 27'h0) begin
      bad++;
      $display("[TB] FAIL reset_fields: id=%h d1=%h d2=%h cfg=%h baud=%h, expected all 0",
               o_msg_id, o_data1, o_data2, o_msg_cfg, o_baud_cfg);
    end
    rst_n = 1'b1;
    rd_check("reset_syscfg", 8'h04, 32'h0);
    rd_check("reset_pending", 8'h08, 32'h0);
    rd_check("reset_laststs", 8'h14, 32'h0);
  endtask

  task automatic test_baud();
    wr(8'h04, 32'h0, 4'hF);
    wr(8'h00, 32'h0012_3456, 4'hF);
    rd_check("baud_locked", 8'h00, 32'h0);
    wr(8'h04, 32'h2, 4'hF);
    total++;
    if (o_cfg_enable !== 1'b1) begin
      bad++;
      $display("[TB] FAIL cfg_enable: got %b, expected 1", o_cfg_enable);
    end
    wr(8'h00, 32'h0012_3456, 4'hF);
    rd_check("baud_write", 8'h00, 32'h0012_3456);
    total++;
    if (o_baud_cfg !== 27'h012_3456) begin
      bad++;
      $display("[TB] FAIL baud_out: got %h, expected 0123456", o_baud_cfg);
    end
    wr(8'h00, 32'hFFFF_FFFF, 4'b0001);
    rd_check("baud_strobe", 8'h00, 32'h0012_34FF);
    wr(8'h04, 32'h0, 4'hF);
  endtask

  task automatic test_priority();
    logic ok;
    wr(8'h20, 32'h100, 4'hF);
    wr(8'h40, 32'h080, 4'hF);
    wr(8'h08, 32'h5, 4'hF);
    wr(8'h04, 32'h1, 4'hF);
    wait_send(ok);
    total++;
    if (o_msg_id !== 30'h080) begin
      bad++;
      $display("[TB] FAIL prio_first_id: got %h, expected 080", o_msg_id);
    end
    if (ok) respond(3'b001);
    wait_send(ok);
    total++;
    if (o_msg_id !== 30'h100) begin
      bad++;
      $display("[TB] FAIL prio_second_id: got %h, expected 100", o_msg_id);
    end
    if (ok) respond(3'b001);
    rd_check("prio_irq_sts", 8'h0C, 32'h5);
    rd_check("prio_last_sts", 8'h14, 32'h0000_0001);
    wr(8'h0C, 32'hF, 4'hF);
  endtask

  task automatic test_retry();
    logic ok;
    int sends;
    int extra;
    sends = 0;
    extra = 0;
    wr(8'h30, 32'h55, 4'hF);
    wr(8'h08, 32'h2, 4'hF);
    for (int k = 0; k < 4; k++) begin
      wait_send(ok);
      if (ok) begin
        sends++;
        respond(3'b010);
      end
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_send) extra++;
    end
    total++;
    if (sends + extra != 4) begin
      bad++;
      $display("[TB] FAIL retry_sends: got %0d pulses, expected 4", sends + extra);
    end
    rd_check("retry_pending", 8'h08, 32'h0);
    rd_check("retry_last_sts", 8'h14, 32'h0001_0302);
    rd_check("retry_irq_sts", 8'h0C, 32'h2);
    wr(8'h0C, 32'hF, 4'hF);
  endtask

  task automatic test_irq_race();
    logic ok;
    logic rdy;
    wr(8'h10, 32'h1, 4'hF);
    wr(8'h08, 32'h1, 4'hF);
    wait_send(ok);
    if (ok) respond(3'b001);
    @(negedge clk);
    total++;
    if (o_irq !== 1'b1) begin
      bad++;
      $display("[TB] FAIL irq_level: got %b, expected 1", o_irq);
    end
    wr(8'h0C, 32'h1, 4'hF);
    total++;
    if (o_irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL irq_clear: got %b, expected 0", o_irq);
    end
    wr(8'h08, 32'h1, 4'hF);
    wait_send(ok);
    i_sts_code = 3'b001;
    @(negedge clk);
    valid = 1'b1; wr_en = 1'b1; addr = 8'h0C; wdata = 32'h1; wstrb = 4'hF;
    @(negedge clk);
    rdy = ready;
    valid = 1'b0; wr_en = 1'b0; i_sts_code = 3'b000;
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL race_ready: got %b, expected 1", rdy);
    end
    rd_check("race_irq_sts", 8'h0C, 32'h1);
    total++;
    if (o_irq !== 1'b1) begin
      bad++;
      $display("[TB] FAIL race_irq: got %b, expected 1", o_irq);
    end
  endtask

  task automatic test_lock_reset();
    logic ok;
    int seen;
    seen = 0;
    wr(8'h04, 32'h0, 4'hF);
    wr(8'h28, 32'hA5A5_A5A5, 4'hF);
    wr(8'h08, 32'h1, 4'hF);
    wr(8'h28, 32'h1234_5678, 4'hF);
    rd_check("lock_data1", 8'h28, 32'hA5A5_A5A5);
    wr(8'h04, 32'h1, 4'hF);
    wait_send(ok);
    total++;
    if (o_data1 !== 32'hA5A5_A5A5) begin
      bad++;
      $display("[TB] FAIL lock_o_data1: got %h, expected a5a5a5a5", o_data1);
    end
    repeat (2) @(negedge clk);
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wait_busy: got %b, expected 1", o_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o_busy !== 1'b0 || o_irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_abort: busy=%b irq=%b, expected 0/0", o_busy, o_irq);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_send) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL reset_no_send: got %0d pulses, expected 0", seen);
    end
    rd_check("reset_abort_pending", 8'h08, 32'h0);
    rd_check("reset_abort_irq", 8'h0C, 32'h0);
  endtask

  task automatic test_random();
    logic ok;
    logic [31:0] v;
    logic [3:0]  s;
    logic [3:0]  mask;
    logic [3:0]  m_pend;
    logic [3:0]  m_irq;
    logic [3:0]  m_en;
    logic [2:0]  code;
    logic [31:0] m_last;
    int retries;
    int exp;
    int guard;
    m_last = 32'h0;
    for (int i = 0; i < NUM_MB; i++) begin
      m_id[i] = '0; m_cfg[i] = '0; m_d1[i] = '0; m_d2[i] = '0;
    end
    for (int round = 0; round < 6; round++) begin
      wr(8'h04, 32'h0, 4'hF);
      for (int m = 0; m < NUM_MB; m++) begin
        m_id[m] = 30'($urandom_range(0, 7));
        wr(8'(8'h20 + 16 * m), {2'b00, m_id[m]}, 4'hF);
        v = $urandom; s = 4'($urandom);
        wr(8'(8'h24 + 16 * m), v, s);
        m_cfg[m] = 5'(merge({27'd0, m_cfg[m]}, v, s));
        v = $urandom; s = 4'($urandom);
        wr(8'(8'h28 + 16 * m), v, s);
        m_d1[m] = merge(m_d1[m], v, s);
        v = $urandom; s = 4'($urandom);
        wr(8'(8'h2C + 16 * m), v, s);
        m_d2[m] = merge(m_d2[m], v, s);
      end
      m_en = 4'($urandom);
      wr(8'h10, {28'd0, m_en}, 4'hF);
      wr(8'h0C, 32'hF, 4'hF);
      m_irq = 4'h0;
      mask = 4'($urandom_range(1, 15));
      wr(8'h08, {$urandom_range(0, 255), 4'h0} | {28'd0, mask}, 4'hF);
      rd_check("rnd_pending_set", 8'h08, {28'd0, mask});
      m_pend = mask;
      retries = 0;
      wr(8'h04, 32'h1, 4'hF);
      guard = 0;
      while (m_pend != 0 && guard < 40) begin
        guard++;
        exp = -1;
        for (int m = 0; m < NUM_MB; m++)
          if (m_pend[m] && (exp < 0 || m_id[m] < m_id[exp])) exp = m;
        wait_send(ok);
        if (!ok) break;
        total++;
        if (o_msg_id !== m_id[exp] || o_msg_cfg !== m_cfg[exp] ||
            o_data1 !== m_d1[exp] || o_data2 !== m_d2[exp]) begin
          bad++;
          $display("[TB] FAIL rnd_frame: got id=%h cfg=%h d1=%h d2=%h, expected mb%0d id=%h cfg=%h d1=%h d2=%h",
                   o_msg_id, o_msg_cfg, o_data1, o_data2, exp, m_id[exp], m_cfg[exp], m_d1[exp], m_d2[exp]);
        end
        case ($urandom_range(0, 2))
          0:       code = 3'b001;
          1:       code = 3'b010;
          default: code = 3'b011;
        endcase
        respond(code);
        if (code == 3'b010 && retries < RETRY_MAX) begin
          retries++;
        end else begin
          m_pend[exp] = 1'b0;
          m_irq[exp]  = 1'b1;
          m_last = (32'(exp) << 16) | (32'(retries) << 8) | 32'(code);
          retries = 0;
        end
      end
      repeat (4) @(negedge clk);
      rd_check("rnd_pending_done", 8'h08, {28'd0, m_pend});
      rd_check("rnd_irq_sts", 8'h0C, {28'd0, m_irq});
      rd_check("rnd_last_sts", 8'h14, m_last);
      total++;
      if (o_irq !== |(m_irq & m_en)) begin
        bad++;
        $display("[TB] FAIL rnd_irq: got %b, expected %b", o_irq, |(m_irq & m_en));
      end
      exp = $urandom_range(0, NUM_MB - 1);
      rd_check("rnd_cfg_rb", 8'(8'h24 + 16 * exp), {27'd0, m_cfg[exp]});
      rd_check("rnd_data2_rb", 8'(8'h2C + 16 * exp), m_d2[exp]);
    end
    wr(8'h60, 32'hDEAD_BEEF, 4'hF);
    rd_check("unmapped_mb4", 8'h60, 32'h0);
    wr(8'h18, 32'hDEAD_BEEF, 4'hF);
    rd_check("unmapped_18", 8'h18, 32'h0);
  endtask

  initial begin
    test_reset();
    test_baud();
    test_priority();
    test_retry();
    test_irq_race();
    test_lock_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
